// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared state encoding and default sizing for the LED shift-register transmitter
package spi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    localparam int DATA_W_DEFAULT  = 8;
    localparam int CLK_DIV_DEFAULT = 2;

endpackage

// File: rtl/spi_led_tx_if.sv
// rtl/spi_led_tx_if.sv - request handshake and serial pins of the LED shift-register transmitter
interface spi_led_tx_if
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              mosi;
    logic              latch;

    modport master (
        output start, data_in,
        input  busy, done, sclk, mosi, latch
    );

    modport slave (
        input  start, data_in,
        output busy, done, sclk, mosi, latch
    );

endinterface

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - sclk phase divider, ticks on the last clk cycle of each phase
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1; restart on every phase boundary and while the FSM is not shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_led_tx.sv
// rtl/spi_led_tx.sv - serialises a word MSB first to an external shift register, then strobes latch
module spi_led_tx
    import spi_tx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    spi_led_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t            state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              tick;
    logic              tick_clear;

    logic busy_q, done_q, sclk_q, mosi_q, latch_q;
    logic busy_next, done_next, sclk_next, mosi_next, latch_next;

    // The divider only runs while a phase is in progress
    assign tick_clear = (state == IDLE) || (state == DONE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Next-state and datapath: accept only in IDLE, shift after each sclk high phase
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next   = SHIFT_LO;
                    shreg_next   = bus.data_in;
                    bit_cnt_next = CNT_W'(DATA_W - 1);
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bit_cnt == '0) begin
                        state_next = LATCH;
                    end else begin
                        state_next   = SHIFT_LO;
                        shreg_next   = {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt_next = bit_cnt - CNT_W'(1);
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered pins line up with the state
    always_comb begin
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        sclk_next  = (state_next == SHIFT_HI);
        latch_next = (state_next == LATCH);
        mosi_next  = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ? shreg_next[DATA_W-1] : 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Registered outputs keep sclk, mosi and latch glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            busy_q  <= busy_next;
            done_q  <= done_next;
            sclk_q  <= sclk_next;
            mosi_q  <= mosi_next;
            latch_q <= latch_next;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sclk  = sclk_q;
    assign bus.mosi  = mosi_q;
    assign bus.latch = latch_q;

endmodule

// File: tb/tb_spi_led_tx.sv
// tb/tb_spi_led_tx.sv - directed bench for spi_led_tx at CLK_DIV=2 and CLK_DIV=1
module tb_spi_led_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    spi_led_tx_if #(.DATA_W(8)) a_if ();
    spi_led_tx_if #(.DATA_W(8)) b_if ();

    spi_led_tx #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    spi_led_tx #(.DATA_W(8), .CLK_DIV(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observers sampled on the falling clk edge
    int          a_busy_n = 0, a_latch_n = 0, a_done_n = 0;
    int          b_busy_n = 0, b_latch_n = 0, b_done_n = 0;
    logic [31:0] a_bits = '0, b_bits = '0;
    logic        a_sclk_q = 1'b0, b_sclk_q = 1'b0;

    always @(negedge clk) begin
        if (a_if.busy)  a_busy_n++;
        if (a_if.latch) a_latch_n++;
        if (a_if.done)  a_done_n++;
        if (a_if.sclk && !a_sclk_q) a_bits = {a_bits[30:0], a_if.mosi};
        a_sclk_q = a_if.sclk;
        if (b_if.busy)  b_busy_n++;
        if (b_if.latch) b_latch_n++;
        if (b_if.done)  b_done_n++;
        if (b_if.sclk && !b_sclk_q) b_bits = {b_bits[30:0], b_if.mosi};
        b_sclk_q = b_if.sclk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int max, output int n);
        n = 0;
        while (!a_if.done && n < max) begin
            step();
            n++;
        end
        check("a_done_seen", 32'(a_if.done), 32'd1);
    endtask

    int busy0, latch0, done0;
    int n, n1, n2;
    logic [15:0] pat;

    initial begin
        a_if.start = 1'b0; a_if.data_in = '0;
        b_if.start = 1'b0; b_if.data_in = '0;

        // Reset state
        repeat (3) step();
        check("rst_outs_a", 32'({a_if.busy, a_if.done, a_if.sclk, a_if.mosi, a_if.latch}), 32'd0);
        check("rst_outs_b", 32'({b_if.busy, b_if.done, b_if.sclk, b_if.mosi, b_if.latch}), 32'd0);
        reset = 1'b0;
        step();

        // A5 single transfer
        a_if.start = 1'b1; a_if.data_in = 8'hA5;
        busy0 = a_busy_n; latch0 = a_latch_n; done0 = a_done_n;
        step();
        a_if.start = 1'b0;
        wait_done_a(100, n);
        check("a5_latency", n, 34);
        repeat (3) step();
        check("a5_word",  a_bits[7:0], 8'hA5);
        check("a5_latch", a_latch_n - latch0, 2);
        check("a5_done",  a_done_n - done0, 1);
        check("a5_busy",  a_busy_n - busy0, 35);
        check("a5_idle",  32'({a_if.busy, a_if.sclk, a_if.mosi, a_if.latch}), 32'd0);

        // 00 then FF back to back with start held high
        a_if.start = 1'b1; a_if.data_in = 8'h00;
        busy0 = a_busy_n; done0 = a_done_n;
        step();
        a_if.data_in = 8'hFF;
        wait_done_a(100, n1);
        step();
        wait_done_a(100, n2);
        a_if.start = 1'b0;
        check("b2b_latency", n1 + 1 + n2, 70);
        repeat (4) step();
        check("b2b_words", a_bits[15:0], 16'h00FF);
        check("b2b_done",  a_done_n - done0, 2);
        check("b2b_busy",  a_busy_n - busy0, 70);

        // Start pulses during SHIFT_HI of bit 3 and during DONE are ignored
        a_if.start = 1'b1; a_if.data_in = 8'h5A;
        busy0 = a_busy_n; done0 = a_done_n;
        step();
        a_if.start = 1'b0;
        repeat (18) step();
        check("ign_in_hi", 32'(a_if.sclk), 32'd1);
        a_if.start = 1'b1; a_if.data_in = 8'hFF;
        step();
        a_if.start = 1'b0;
        wait_done_a(100, n);
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        check("ign_in_done", 32'(a_if.busy), 32'd0);
        repeat (4) step();
        check("ign_word", a_bits[7:0], 8'h5A);
        check("ign_done", a_done_n - done0, 1);
        check("ign_busy", a_busy_n - busy0, 35);

        // data_in churns after acceptance of 3C
        a_if.start = 1'b1; a_if.data_in = 8'h3C;
        done0 = a_done_n;
        step();
        a_if.start = 1'b0;
        n = 0;
        while (!a_if.done && n < 100) begin
            a_if.data_in = 8'($urandom);
            step();
            n++;
        end
        repeat (3) step();
        check("churn_word", a_bits[7:0], 8'h3C);
        check("churn_done", a_done_n - done0, 1);

        // Reset during bit 5 aborts silently
        a_if.start = 1'b1; a_if.data_in = 8'hFF;
        latch0 = a_latch_n; done0 = a_done_n;
        step();
        a_if.start = 1'b0;
        repeat (9) step();
        check("abort_busy_pre", 32'(a_if.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_async", 32'({a_if.busy, a_if.done, a_if.sclk, a_if.mosi, a_if.latch}), 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (40) step();
        check("abort_latch", a_latch_n - latch0, 0);
        check("abort_done",  a_done_n - done0, 0);
        a_if.start = 1'b1; a_if.data_in = 8'hC3;
        done0 = a_done_n;
        step();
        a_if.start = 1'b0;
        check("post_rst_accept", 32'(a_if.busy), 32'd1);
        wait_done_a(100, n);
        repeat (3) step();
        check("post_rst_word", a_bits[7:0], 8'hC3);
        check("post_rst_done", a_done_n - done0, 1);

        // CLK_DIV=1 build with 81
        b_if.start = 1'b1; b_if.data_in = 8'h81;
        busy0 = b_busy_n; done0 = b_done_n;
        step();
        b_if.start = 1'b0;
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            pat = {pat[14:0], b_if.sclk};
            step();
        end
        check("div1_sclk", pat, 16'h5555);
        check("div1_latch_cyc", 32'(b_if.latch), 32'd1);
        step();
        check("div1_done_cyc", 32'(b_if.done), 32'd1);
        repeat (3) step();
        check("div1_word", b_bits[7:0], 8'h81);
        check("div1_busy", b_busy_n - busy0, 18);
        check("div1_done", b_done_n - done0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
